// File: rtl/pacman_mover.sv
// pacman_mover: tile-aligned, rate-limited Pac-Man position controller.
// Button presses become a wanted direction. Every STEP_DIV enabled cycles a
// decision is made. Between tiles the sprite keeps moving, or turns back if
// the opposite direction is wanted. On a tile boundary it asks the maze (via
// a req/ack query) whether the next tile is free.
// Ports:
//   i_clk, i_rst           clock, asynchronous active-high reset
//   i_en                   movement enable (freezes tick counter and WAIT)
//   i_up/down/left/right   level buttons (left > right > up > down)
//   o_req, o_qx, o_qy      maze query request and queried tile (row, col)
//   i_ack, i_blocked       query acknowledge and wall flag
//   o_x, o_y               sprite row / column pixel coordinate
//   o_dir                  0 up, 1 down, 2 left, 3 right
//   o_moving               sprite is in motion
module pacman_mover #(
  parameter int W        = 10,
  parameter int X_MAX    = 272,
  parameter int Y_MAX    = 208,
  parameter int X_INIT   = 8,
  parameter int Y_INIT   = 8,
  parameter int TILE     = 8,
  parameter int STEP_DIV = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_up,
  input  logic         i_down,
  input  logic         i_left,
  input  logic         i_right,
  output logic         o_req,
  output logic [W-1:0] o_qx,
  output logic [W-1:0] o_qy,
  input  logic         i_ack,
  input  logic         i_blocked,
  output logic [W-1:0] o_x,
  output logic [W-1:0] o_y,
  output logic [1:0]   o_dir,
  output logic         o_moving
);

  localparam int SH = $clog2(TILE);
  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STEP_DIV - 1);
  // One extra bit so bound checks on coordinate + TILE cannot overflow.
  localparam logic [W:0] TILE_E = (W+1)'(TILE);
  localparam logic [W:0] XMAX_E = (W+1)'(X_MAX);
  localparam logic [W:0] YMAX_E = (W+1)'(Y_MAX);

  typedef enum logic [1:0] {S_WAIT, S_Q_WANT, S_Q_CUR, S_STEP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  x_q, x_d, y_q, y_d, qx_q, qx_d, qy_q, qy_d;
  logic [1:0]    dir_q, dir_d, want_q, want_d;
  logic          moving_q, moving_d, req_q, req_d, want_v_q, want_v_d;

  // Target pixel one tile away along d falls outside the maze.
  function automatic logic is_oob(input logic [1:0] d, input logic [W-1:0] x,
                                  input logic [W-1:0] y);
    logic [W:0] xe, ye;
    xe = {1'b0, x};
    ye = {1'b0, y};
    case (d)
      2'd0:    is_oob = (xe < TILE_E);
      2'd1:    is_oob = ((xe + TILE_E) > XMAX_E);
      2'd2:    is_oob = (ye < TILE_E);
      default: is_oob = ((ye + TILE_E) > YMAX_E);
    endcase
  endfunction

  // Neighbouring tile index along d, packed {row, col}.
  function automatic logic [2*W-1:0] tile_of(input logic [1:0] d, input logic [W-1:0] x,
                                             input logic [W-1:0] y);
    logic [W-1:0] tx, ty;
    tx = x >> SH;
    ty = y >> SH;
    case (d)
      2'd0:    tx = tx - W'(1);
      2'd1:    tx = tx + W'(1);
      2'd2:    ty = ty - W'(1);
      default: ty = ty + W'(1);
    endcase
    tile_of = {tx, ty};
  endfunction

  logic           aligned, want_oob, dir_oob, any_btn;
  logic [2*W-1:0] want_tile, dir_tile;

  assign aligned   = (x_q[SH-1:0] == '0) && (y_q[SH-1:0] == '0);
  assign want_oob  = is_oob(want_q, x_q, y_q);
  assign dir_oob   = is_oob(dir_q, x_q, y_q);
  assign want_tile = tile_of(want_q, x_q, y_q);
  assign dir_tile  = tile_of(dir_q, x_q, y_q);
  assign any_btn   = i_up | i_down | i_left | i_right;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    dir_d    = dir_q;
    moving_d = moving_q;
    req_d    = req_q;
    qx_d     = qx_q;
    qy_d     = qy_q;
    want_d   = want_q;
    want_v_d = want_v_q;
    unique case (state_q)
      S_WAIT: begin
        if (i_en) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            // Up/down and left/right differ only in bit 0.
            if (want_v_q && moving_q && (want_q == (dir_q ^ 2'd1))) begin
              dir_d    = want_q;
              want_v_d = 1'b0;
              state_d  = S_STEP;
            end else if (!aligned && moving_q) begin
              state_d = S_STEP;
            end else if (aligned && want_v_q && !want_oob) begin
              state_d        = S_Q_WANT;
              req_d          = 1'b1;
              {qx_d, qy_d}   = want_tile;
            end else if (aligned && moving_q) begin
              // No wish, or the wish leaves the maze: try to keep going.
              if (dir_oob) begin
                moving_d = 1'b0;
              end else begin
                state_d      = S_Q_CUR;
                req_d        = 1'b1;
                {qx_d, qy_d} = dir_tile;
              end
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_Q_WANT: begin
        if (i_ack) begin
          req_d = 1'b0;
          if (!i_blocked) begin
            dir_d    = want_q;
            want_v_d = 1'b0;
            moving_d = 1'b1;
            state_d  = S_STEP;
          end else if (moving_q && !dir_oob) begin
            // Request drops for a cycle, then Q_CUR reissues it.
            state_d = S_Q_CUR;
          end else begin
            moving_d = 1'b0;
            state_d  = S_WAIT;
          end
        end
      end
      S_Q_CUR: begin
        if (!req_q) begin
          req_d        = 1'b1;
          {qx_d, qy_d} = dir_tile;
        end else if (i_ack) begin
          req_d = 1'b0;
          if (i_blocked) begin
            moving_d = 1'b0;
            state_d  = S_WAIT;
          end else begin
            state_d = S_STEP;
          end
        end
      end
      S_STEP: begin
        state_d = S_WAIT;
        case (dir_q)
          2'd0:    if (x_q != '0) x_d = x_q - W'(1); else moving_d = 1'b0;
          2'd1:    if ({1'b0, x_q} < XMAX_E) x_d = x_q + W'(1); else moving_d = 1'b0;
          2'd2:    if (y_q != '0) y_d = y_q - W'(1); else moving_d = 1'b0;
          default: if ({1'b0, y_q} < YMAX_E) y_d = y_q + W'(1); else moving_d = 1'b0;
        endcase
      end
    endcase
    // A press in the same cycle as adoption wins, so a held button stays wanted.
    if (any_btn) begin
      want_v_d = 1'b1;
      if (i_left)       want_d = 2'd2;
      else if (i_right) want_d = 2'd3;
      else if (i_up)    want_d = 2'd0;
      else              want_d = 2'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_WAIT;
      cnt_q    <= '0;
      x_q      <= W'(X_INIT);
      y_q      <= W'(Y_INIT);
      dir_q    <= 2'd0;
      moving_q <= 1'b0;
      req_q    <= 1'b0;
      qx_q     <= '0;
      qy_q     <= '0;
      want_q   <= 2'd0;
      want_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dir_q    <= dir_d;
      moving_q <= moving_d;
      req_q    <= req_d;
      qx_q     <= qx_d;
      qy_q     <= qy_d;
      want_q   <= want_d;
      want_v_q <= want_v_d;
    end
  end

  assign o_req    = req_q;
  assign o_qx     = qx_q;
  assign o_qy     = qy_q;
  assign o_x      = x_q;
  assign o_y      = y_q;
  assign o_dir    = dir_q;
  assign o_moving = moving_q;

endmodule
